// File: rtl/afns_weight_cfg_pkg.sv
// Shared definitions for the adaptive-FNS weight configuration sequencer.
// The sequencer walks the TSV map once per configuration request.
package afns_weight_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MAX_N = 16;

endpackage

// File: rtl/afns_weight_step.sv
// One step of the Fibonacci weight recurrence for a single bit position.
// The first two usable positions both weigh 1; later positions weigh a+b, saturating.
module afns_weight_step #(
    parameter int WW = 4,
    parameter int NW = 3
) (
    input  logic [WW-1:0] i_a,
    input  logic [WW-1:0] i_b,
    input  logic [NW-1:0] i_seen,
    input  logic          i_usable,
    output logic [WW-1:0] o_w,
    output logic          o_sat,
    output logic [WW-1:0] o_nextA,
    output logic [WW-1:0] o_nextB
);

    logic [WW:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};

    // Unusable positions get weight 0 and leave the running pair untouched.
    always_comb begin
        o_w     = '0;
        o_sat   = 1'b0;
        o_nextA = i_a;
        o_nextB = i_b;
        if (i_usable) begin
            if (i_seen < NW'(2)) begin
                o_w = WW'(1);
            end else if (w_sum[WW]) begin
                o_w   = '1;
                o_sat = 1'b1;
            end else begin
                o_w = w_sum[WW-1:0];
            end
            o_nextA = i_b;
            o_nextB = o_w;
        end
    end

endmodule

// File: rtl/afns_weight_cfg.sv
// Configuration sequencer for one adaptive-FNS coder group: computes per-position
// Fibonacci weights from the TSV usability map, one position per clock, plus capacity.
module afns_weight_cfg
    import afns_weight_cfg_pkg::*;
#(
    parameter  int N  = 5,
    parameter  int WW = 4,
    localparam int CW = WW + $clog2(N),
    localparam int NW = $clog2(N + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            cfg_start,
    input  logic [N-1:0]    en_map,
    output logic            cfg_busy,
    output logic            cfg_done,
    output logic            cfg_valid,
    output logic [N-1:0]    en_flag,
    output logic [N*WW-1:0] fns_w,
    output logic [CW-1:0]   cap_max,
    output logic [NW-1:0]   n_usable,
    output logic            ovf
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t               r_state;
    state_t               w_nextState;
    logic [IW-1:0]        r_idx;
    logic [WW-1:0]        r_a;
    logic [WW-1:0]        r_b;
    logic [N-1:0]         r_enFlag;
    logic [N-1:0][WW-1:0] r_fnsW;
    logic [CW-1:0]        r_capMax;
    logic [NW-1:0]        r_nUsable;
    logic                 r_ovf;
    logic                 r_valid;

    logic                 w_usable;
    logic                 w_last;
    logic [WW-1:0]        w_w;
    logic                 w_sat;
    logic [WW-1:0]        w_nextA;
    logic [WW-1:0]        w_nextB;

    assign w_usable = r_enFlag[r_idx];
    assign w_last   = (r_idx == IW'(N - 1));

    afns_weight_step #(
        .WW(WW),
        .NW(NW)
    ) u_step (
        .i_a     (r_a),
        .i_b     (r_b),
        .i_seen  (r_nUsable),
        .i_usable(w_usable),
        .o_w     (w_w),
        .o_sat   (w_sat),
        .o_nextA (w_nextA),
        .o_nextB (w_nextB)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (cfg_start) w_nextState = ST_SCAN;
            ST_SCAN: if (w_last)    w_nextState = ST_DONE;
            ST_DONE:                w_nextState = ST_IDLE;
            default:                w_nextState = ST_IDLE;
        endcase
    end

    // Valid is raised on the last scan step so it coincides with the DONE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_enFlag  <= '0;
            r_fnsW    <= '0;
            r_capMax  <= '0;
            r_nUsable <= '0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        r_enFlag  <= en_map;
                        r_fnsW    <= '0;
                        r_capMax  <= '0;
                        r_nUsable <= '0;
                        r_ovf     <= 1'b0;
                        r_a       <= '0;
                        r_b       <= '0;
                        r_idx     <= '0;
                        r_valid   <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    r_fnsW[r_idx] <= w_w;
                    if (w_usable) begin
                        r_a       <= w_nextA;
                        r_b       <= w_nextB;
                        r_nUsable <= r_nUsable + 1'b1;
                        r_capMax  <= r_capMax + CW'(w_w);
                        r_ovf     <= r_ovf | w_sat;
                    end
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cfg_busy  = (r_state != ST_IDLE);
    assign cfg_done  = (r_state == ST_DONE);
    assign cfg_valid = r_valid;
    assign en_flag   = r_enFlag;
    assign fns_w     = r_fnsW;
    assign cap_max   = r_capMax;
    assign n_usable  = r_nUsable;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_afns_weight_cfg.sv
// Directed, table-driven bench for afns_weight_cfg at WW=4 and WW=2 (saturating).
module tb_afns_weight_cfg;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic [4:0]  en_map;

    logic        cfg_busy, cfg_done, cfg_valid, ovf;
    logic [4:0]  en_flag;
    logic [19:0] fns_w;
    logic [6:0]  cap_max;
    logic [2:0]  n_usable;

    logic        cfg_busy2, cfg_done2, cfg_valid2, ovf2;
    logic [4:0]  en_flag2;
    logic [9:0]  fns_w2;
    logic [4:0]  cap_max2;
    logic [2:0]  n_usable2;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        logic [4:0]  map;
        logic [19:0] w;
        logic [6:0]  cap;
        logic [2:0]  nU;
        logic        ovf;
        logic [9:0]  w2;
        logic [4:0]  cap2;
        logic        ovf2;
    } vec_t;

    vec_t vecs[6];

    always #5 clock = ~clock;

    afns_weight_cfg #(.N(5), .WW(4)) dut (
        .clock(clock), .reset(reset), .cfg_start(cfg_start), .en_map(en_map),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_valid(cfg_valid),
        .en_flag(en_flag), .fns_w(fns_w), .cap_max(cap_max),
        .n_usable(n_usable), .ovf(ovf)
    );

    afns_weight_cfg #(.N(5), .WW(2)) dutSat (
        .clock(clock), .reset(reset), .cfg_start(cfg_start), .en_map(en_map),
        .cfg_busy(cfg_busy2), .cfg_done(cfg_done2), .cfg_valid(cfg_valid2),
        .en_flag(en_flag2), .fns_w(fns_w2), .cap_max(cap_max2),
        .n_usable(n_usable2), .ovf(ovf2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pulse start with the given map and wait (bounded) for cfg_done.
    task automatic applyStimulus(input logic [4:0] map, output int lat);
        cfg_start = 1'b1;
        en_map    = map;
        tick();
        cfg_start = 1'b0;
        checkOutput("busyInScan", 32'(cfg_busy), 32'd1);
        checkOutput("validLowInScan", 32'(cfg_valid), 32'd0);
        lat = 1;
        while (!cfg_done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int doneCnt;
        int doneAt;

        vecs[0] = '{5'b11111, 20'h53211, 7'd12, 3'd5, 1'b0, 10'b11_11_10_01_01, 5'd10, 1'b1};
        vecs[1] = '{5'b11011, 20'h32011, 7'd7,  3'd4, 1'b0, 10'b11_10_00_01_01, 5'd7,  1'b0};
        vecs[2] = '{5'b00000, 20'h00000, 7'd0,  3'd0, 1'b0, 10'b00_00_00_00_00, 5'd0,  1'b0};
        vecs[3] = '{5'b01000, 20'h01000, 7'd1,  3'd1, 1'b0, 10'b00_01_00_00_00, 5'd1,  1'b0};
        vecs[4] = '{5'b10101, 20'h20101, 7'd4,  3'd3, 1'b0, 10'b10_00_01_00_01, 5'd4,  1'b0};
        vecs[5] = '{5'b10000, 20'h10000, 7'd1,  3'd1, 1'b0, 10'b01_00_00_00_00, 5'd1,  1'b0};

        reset     = 1'b1;
        cfg_start = 1'b0;
        en_map    = 5'b0;
        tick();
        tick();
        reset = 1'b0;

        checkOutput("rstBusy",  32'(cfg_busy),  32'd0);
        checkOutput("rstDone",  32'(cfg_done),  32'd0);
        checkOutput("rstValid", 32'(cfg_valid), 32'd0);
        checkOutput("rstFnsW",  32'(fns_w),     32'd0);
        checkOutput("rstCap",   32'(cap_max),   32'd0);
        checkOutput("rstEn",    32'(en_flag),   32'd0);
        checkOutput("rstOvf",   32'(ovf),       32'd0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].map, lat);
            checkOutput("latency",  32'(lat),       32'd6);
            checkOutput("done",     32'(cfg_done),  32'd1);
            checkOutput("doneSat",  32'(cfg_done2), 32'd1);
            checkOutput("busyDone", 32'(cfg_busy),  32'd1);
            checkOutput("valid",    32'(cfg_valid), 32'd1);
            checkOutput("fnsW",     32'(fns_w),     32'(vecs[i].w));
            checkOutput("capMax",   32'(cap_max),   32'(vecs[i].cap));
            checkOutput("nUsable",  32'(n_usable),  32'(vecs[i].nU));
            checkOutput("ovf",      32'(ovf),       32'(vecs[i].ovf));
            checkOutput("enFlag",   32'(en_flag),   32'(vecs[i].map));
            checkOutput("fnsWSat",  32'(fns_w2),    32'(vecs[i].w2));
            checkOutput("capSat",   32'(cap_max2),  32'(vecs[i].cap2));
            checkOutput("ovfSat",   32'(ovf2),      32'(vecs[i].ovf2));
            checkOutput("validSat", 32'(cfg_valid2), 32'd1);
            tick();
            checkOutput("donePulse",  32'(cfg_done),  32'd0);
            checkOutput("idleBusy",   32'(cfg_busy),  32'd0);
            checkOutput("validHolds", 32'(cfg_valid), 32'd1);
        end

        // Restart request and map toggling during SCAN must be ignored.
        cfg_start = 1'b1;
        en_map    = 5'b11011;
        tick();
        cfg_start = 1'b0;
        doneCnt   = 0;
        doneAt    = 0;
        for (int k = 1; k <= 9; k++) begin
            if (cfg_done) begin
                doneCnt++;
                doneAt = k;
            end
            if (k == 1) en_map = 5'b00100;
            if (k == 2) begin
                cfg_start = 1'b1;
                en_map    = 5'b11111;
            end
            if (k == 3) begin
                cfg_start = 1'b0;
                en_map    = 5'b00000;
            end
            tick();
        end
        checkOutput("ignoreDoneCnt", 32'(doneCnt), 32'd1);
        checkOutput("ignoreDoneAt",  32'(doneAt),  32'd6);
        checkOutput("ignoreFnsW",    32'(fns_w),   32'h32011);
        checkOutput("ignoreCap",     32'(cap_max), 32'd7);
        checkOutput("ignoreEn",      32'(en_flag), 32'b11011);
        checkOutput("ignoreBusy",    32'(cfg_busy), 32'd0);

        // Reset in the middle of a scan aborts it.
        cfg_start = 1'b1;
        en_map    = 5'b11111;
        tick();
        cfg_start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abortBusy",  32'(cfg_busy),  32'd0);
        checkOutput("abortDone",  32'(cfg_done),  32'd0);
        checkOutput("abortValid", 32'(cfg_valid), 32'd0);
        checkOutput("abortFnsW",  32'(fns_w),     32'd0);
        checkOutput("abortCap",   32'(cap_max),   32'd0);
        checkOutput("abortNUse",  32'(n_usable),  32'd0);
        checkOutput("abortEn",    32'(en_flag),   32'd0);
        tick();
        checkOutput("abortNoDone", 32'(cfg_done), 32'd0);
        applyStimulus(5'b01000, lat);
        checkOutput("freshLatency", 32'(lat),     32'd6);
        checkOutput("freshFnsW",    32'(fns_w),   32'h01000);
        checkOutput("freshCap",     32'(cap_max), 32'd1);
        tick();

        // Reset and start together: reset wins.
        reset     = 1'b1;
        cfg_start = 1'b1;
        en_map    = 5'b11111;
        tick();
        reset     = 1'b0;
        cfg_start = 1'b0;
        checkOutput("rstWinsBusy", 32'(cfg_busy), 32'd0);
        checkOutput("rstWinsEn",   32'(en_flag),  32'd0);
        tick();
        checkOutput("rstWinsIdle", 32'(cfg_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
